// File: rtl/logic_op_issuer.sv
// logic_op_issuer
// Accepts one logic operation at a time from an upstream requester, drives it
// to an external registered logic unit, captures the unit's result one cycle
// later and queues it (with zero/negative flags) in a small result FIFO.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  upstream request present
//   req_ready  request accepted this cycle (IDLE and buffer not full)
//   req_op     00 NOT a, 01 AND, 10 OR, 11 XOR
//   req_a      operand A
//   req_b      operand B (registered but unused by NOT)
//   lu_op      opcode held for the logic unit
//   lu_a       operand A held for the logic unit
//   lu_b       operand B held for the logic unit
//   lu_res     logic unit registered result, valid one cycle after issue
//   res_valid  result buffer non-empty
//   res_ready  downstream consumes the head entry
//   res_data   head result
//   res_zero   head result is zero
//   res_neg    head result MSB
module logic_op_issuer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [1:0]       lu_op,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    input  logic [WIDTH-1:0] lu_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] buf_data [DEPTH];
    logic             buf_zero [DEPTH];
    logic             buf_neg  [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // Next-state and handshake decode. req_ready is also gated by rst so the
    // upstream never sees a ready while the block is held in reset.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst && (count < FULL_COUNT);
                accept    = req_valid && req_ready;
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                push       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign res_valid = (count != '0);
    assign pop       = res_valid && res_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers feeding the logic unit; they only change on an
    // accepted request so the unit sees stable inputs through ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_op <= '0;
            lu_a  <= '0;
            lu_b  <= '0;
        end else if (accept) begin
            lu_op <= req_op;
            lu_a  <= req_a;
            lu_b  <= req_b;
        end
    end

    // FIFO bookkeeping. Pointers wrap naturally because DEPTH is a power of
    // two. A push can never hit a full buffer since requests are only taken
    // while count < DEPTH and only one operation is ever in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Result storage. Flags are computed once at write time so the head
    // outputs are pure reads of the stored entry.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= lu_res;
            buf_zero[wr_ptr] <= (lu_res == '0);
            buf_neg[wr_ptr]  <= lu_res[WIDTH-1];
        end
    end

    assign res_data = buf_data[rd_ptr];
    assign res_zero = buf_zero[rd_ptr];
    assign res_neg  = buf_neg[rd_ptr];

endmodule

// File: doc/logic_op_issuer.md
LOGIC_OP_ISSUER -- requirements
Module: logic_op_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, result buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  upstream operation request present.
REQ-006 SHALL have port req_ready  output  1  issuer accepts request this cycle.
REQ-007 SHALL have port req_op  input  2  00 NOT a, 01 AND, 10 OR, 11 XOR.
REQ-008 SHALL have port req_a  input  WIDTH  operand A.
REQ-009 SHALL have port req_b  input  WIDTH  operand B, ignored for NOT.
REQ-010 SHALL have port lu_op  output  2  opcode driven to registered logic unit.
REQ-011 SHALL have port lu_a  output  WIDTH  operand A driven to logic unit.
REQ-012 SHALL have port lu_b  output  WIDTH  operand B driven to logic unit.
REQ-013 SHALL have port lu_res  input  WIDTH  logic unit registered result, valid one cycle after issue.
REQ-014 SHALL have port res_valid  output  1  result buffer non-empty.
REQ-015 SHALL have port res_ready  input  1  downstream consumes head entry.
REQ-016 SHALL have port res_data  output  WIDTH  head result.
REQ-017 SHALL have port res_zero  output  1  head result == 0.
REQ-018 SHALL have port res_neg  output  1  head result MSB.

Function
REQ-019 SHALL implement FSM IDLE, ISSUE, CAPTURE; IDLE on reset.
REQ-020 SHALL assert req_ready only in IDLE and only when buffer count < DEPTH.
REQ-021 SHALL, on req_valid && req_ready, register op/a/b into lu_op/lu_a/lu_b and go IDLE->ISSUE.
REQ-022 SHALL hold lu_op/lu_a/lu_b stable from ISSUE until the next accepted request; ISSUE->CAPTURE unconditionally.
REQ-023 SHALL, in CAPTURE, write lu_res with computed zero/neg flags into buffer tail and return to IDLE.
REQ-024 SHALL give latency: accept at edge N, result visible on res_data after edge N+2 when buffer previously empty.
REQ-025 SHALL sustain one operation per 3 cycles; at most one operation in flight.
REQ-026 SHALL treat buffer as FIFO: pop on res_valid && res_ready, head advances; res_data/flags follow head combinationally from stored entry.
REQ-027 SHALL permit simultaneous CAPTURE write and pop; count unchanged, ordering preserved.
REQ-028 SHALL wrap read/write pointers modulo DEPTH.
REQ-029 SHALL never overflow: a request is accepted only if count < DEPTH; CAPTURE slot is therefore always free.
REQ-030 SHALL ignore res_ready when empty; req_ready=0 when full, even if res_ready=1 that cycle.
REQ-031 SHALL ignore req_b content for NOT but still register it.

Reset
REQ-032 SHALL, on rst low at any time, asynchronously force state IDLE, pointers and count 0, lu_op/lu_a/lu_b 0, res_valid 0, req_ready 0 during reset.
REQ-033 SHALL discard any in-flight operation and buffered results on reset; req_ready=1 first cycle after rst rises.

Verification
REQ-034 SHALL cover: rst low 15 ns, then NOT a=16'h000B -> res_data 16'hFFF4, res_zero 0, res_neg 1, at edge N+2.
REQ-035 SHALL cover: XOR a=16'hF00F b=16'hF00F -> res_data 16'h0000, res_zero 1, res_neg 0.
REQ-036 SHALL cover: res_ready=0, issue AND 16'hFF00&16'h0FF0 then OR 16'h00F0|16'h000F -> req_ready 0 after second accept; results pop in order 16'h0F00, 16'h00FF.
REQ-037 SHALL cover: buffer holding one entry, res_ready=1 in the CAPTURE cycle -> count stays 1, new result at head next cycle.
REQ-038 SHALL cover: rst asserted during ISSUE of NOT 16'hFFFF -> res_valid 0, no result emitted after release.
REQ-039 SHALL cover: 8 back-to-back ops with res_ready=1 -> 8 correct results, pointer wrap exercised, req_ready pattern 1 every 3 cycles.
